// File: rtl/fbcpu_memory_if.sv
// rtl/fbcpu_memory_if.sv - FB-CPU memory bus, loader stream and output-port signals
interface fbcpu_memory_if #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
);
  logic [ADDRESS_WIDTH-1:0] MAR;
  logic                     RAMWr;
  logic [DATA_WIDTH-1:0]    MDRIn;
  logic [DATA_WIDTH-1:0]    MDROut;
  logic                     ld_start;
  logic [ADDRESS_WIDTH:0]   ld_len;
  logic                     ld_valid;
  logic [DATA_WIDTH-1:0]    ld_data;
  logic                     ld_ready;
  logic                     ld_done;
  logic                     cpu_hold;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_valid;

  modport master (
    output MAR, RAMWr, MDRIn, ld_start, ld_len, ld_valid, ld_data,
    input  MDROut, ld_ready, ld_done, cpu_hold, out_data, out_valid
  );

  modport slave (
    input  MAR, RAMWr, MDRIn, ld_start, ld_len, ld_valid, ld_data,
    output MDROut, ld_ready, ld_done, cpu_hold, out_data, out_valid
  );
endinterface

// File: rtl/fbcpu_memory.sv
// rtl/fbcpu_memory.sv - 64x10 FB-CPU program/data memory with clear-on-reset and streamed loader
// Optional output port at address DEPTH-1 is enabled by defining FBMEM_OUTPORT_EN.
module fbcpu_memory #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int DEPTH         = 1 << ADDRESS_WIDTH
) (
  input logic             clk,
  input logic             rst,
  fbcpu_memory_if.slave   bus
);
  typedef enum logic [1:0] {CLEAR, SERVE, LOAD} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH:0]   DEPTH_LEN = (ADDRESS_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDRESS_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDRESS_WIDTH:0]   len_eff;
  logic [DATA_WIDTH-1:0]    mdr_q, mdr_d;
  logic                     done_q, done_d;
  logic                     ready_q;
  logic                     hold_q;
  logic                     we;
  logic [ADDRESS_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0]    wdata;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    we      = 1'b0;
    waddr   = bus.MAR;
    wdata   = bus.MDRIn;
    len_eff = (bus.ld_len > DEPTH_LEN) ? DEPTH_LEN : bus.ld_len;
    case (state_q)
      CLEAR: begin
        we    = 1'b1;
        waddr = ptr_q;
        wdata = '0;
        ptr_d = ptr_q + ADDRESS_WIDTH'(1);
        if (ptr_q == LAST_ADDR) state_d = SERVE;
      end
      SERVE: begin
        we = bus.RAMWr;
        if (bus.ld_start) begin
          if (len_eff == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = LOAD;
            ptr_d   = '0;
            cnt_d   = len_eff;
          end
        end
      end
      LOAD: begin
        if (bus.ld_valid && ready_q) begin
          we    = 1'b1;
          waddr = ptr_q;
          wdata = bus.ld_data;
          if (ptr_q != LAST_ADDR) ptr_d = ptr_q + ADDRESS_WIDTH'(1);
          cnt_d = cnt_q - (ADDRESS_WIDTH + 1)'(1);
          if (cnt_q == (ADDRESS_WIDTH + 1)'(1)) begin
            state_d = SERVE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
    // Read-first: the array read sees the word before this cycle's write lands.
    mdr_d = (state_q == SERVE && state_d == SERVE) ? mem[bus.MAR] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      cnt_q   <= '0;
      mdr_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      mdr_q   <= mdr_d;
      done_q  <= done_d;
      ready_q <= (state_d == LOAD);
      hold_q  <= (state_d != SERVE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && we) mem[waddr] <= wdata;
  end

  assign bus.MDROut   = mdr_q;
  assign bus.ld_ready = ready_q;
  assign bus.ld_done  = done_q;
  assign bus.cpu_hold = hold_q;

`ifdef FBMEM_OUTPORT_EN
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  port_wr;

  assign port_wr = (state_q == SERVE) && bus.RAMWr && (bus.MAR == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= port_wr;
      if (port_wr) out_data_q <= bus.MDRIn;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
`else
  assign bus.out_data  = '0;
  assign bus.out_valid = 1'b0;
`endif
endmodule

// File: tb/tb_fbcpu_memory.sv
// tb/tb_fbcpu_memory.sv - randomized self-checking bench for fbcpu_memory against a word-array model
module tb_fbcpu_memory;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fbcpu_memory_if #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10)) bus ();

  fbcpu_memory #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef FBMEM_OUTPORT_EN
  localparam bit OUTPORT_EN = 1'b1;
`else
  localparam bit OUTPORT_EN = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] ref_mem [64];
  logic [9:0] exp_od;
  logic [9:0] ld_words [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.RAMWr    = 1'b0;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
  endtask

  task automatic do_reset();
    int n;
    bit saw_done;
    rst = 1'b1;
    idle_inputs();
    cyc();
    rst = 1'b0;
    check("rst_mdrout", bus.MDROut, 0);
    check("rst_ld_ready", bus.ld_ready, 0);
    check("rst_ld_done", bus.ld_done, 0);
    check("rst_cpu_hold", bus.cpu_hold, 1);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_valid", bus.out_valid, 0);
    n = 1;
    saw_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (!bus.cpu_hold) break;
      n++;
      if (bus.ld_done || bus.ld_ready) saw_done = 1'b1;
    end
    check("clear_cycles", n, 64);
    check("clear_no_loader", saw_done, 0);
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    exp_od = '0;
  endtask

  task automatic do_serve(input logic [5:0] a, input bit we, input logic [9:0] d);
    logic [9:0] exp_rd;
    bit exp_ov;
    exp_rd = ref_mem[a];
    exp_ov = OUTPORT_EN && we && (a == 6'd63);
    bus.MAR   = a;
    bus.RAMWr = we;
    bus.MDRIn = d;
    if (we) ref_mem[a] = d;
    if (exp_ov) exp_od = d;
    cyc();
    bus.RAMWr = 1'b0;
    check("serve_rd", bus.MDROut, exp_rd);
    check("serve_hold", bus.cpu_hold, 0);
    check("serve_out_valid", bus.out_valid, exp_ov);
    check("serve_out_data", bus.out_data, exp_od);
  endtask

  task automatic do_load(input int len, input bit gaps, input int abort_after);
    int eff;
    logic [5:0] ca;
    logic [9:0] cd, w;
    eff = (len > 64) ? 64 : len;
    ca = 6'($urandom);
    cd = 10'($urandom);
    bus.ld_start = 1'b1;
    bus.ld_len   = 7'(len);
    bus.MAR      = ca;
    bus.MDRIn    = cd;
    bus.RAMWr    = 1'b1;
    ref_mem[ca]  = cd;
    if (OUTPORT_EN && ca == 6'd63) exp_od = cd;
    cyc();
    bus.ld_start = 1'b0;
    bus.RAMWr    = 1'b0;
    if (eff == 0) begin
      check("len0_done", bus.ld_done, 1);
      check("len0_hold", bus.cpu_hold, 0);
      check("len0_ready", bus.ld_ready, 0);
      cyc();
      check("len0_done_drop", bus.ld_done, 0);
      return;
    end
    check("load_ready", bus.ld_ready, 1);
    check("load_hold", bus.cpu_hold, 1);
    check("load_mdrout", bus.MDROut, 0);
    for (int i = 0; i < eff; i++) begin
      if (i == abort_after) begin
        bus.ld_valid = 1'b0;
        do_reset();
        return;
      end
      if (gaps && i > 0) begin
        bus.ld_valid = 1'b0;
        bus.RAMWr    = 1'b1;
        bus.MAR      = 6'($urandom);
        bus.MDRIn    = 10'($urandom);
        cyc();
        bus.RAMWr = 1'b0;
        check("gap_ready", bus.ld_ready, 1);
        check("gap_done", bus.ld_done, 0);
        check("gap_mdrout", bus.MDROut, 0);
      end
      w = (ld_words.size() > 0) ? ld_words.pop_front() : 10'($urandom);
      ref_mem[i]   = w;
      bus.ld_valid = 1'b1;
      bus.ld_data  = w;
      bus.RAMWr    = 1'($urandom);
      bus.MAR      = 6'($urandom);
      bus.MDRIn    = 10'($urandom);
      bus.ld_start = 1'($urandom);
      bus.ld_len   = 7'($urandom);
      cyc();
      bus.ld_valid = 1'b0;
      bus.RAMWr    = 1'b0;
      bus.ld_start = 1'b0;
      if (i == eff - 1) begin
        check("load_done", bus.ld_done, 1);
        check("load_end_hold", bus.cpu_hold, 0);
        check("load_end_ready", bus.ld_ready, 0);
      end else begin
        check("load_mid_done", bus.ld_done, 0);
        check("load_mid_ready", bus.ld_ready, 1);
        check("load_mid_hold", bus.cpu_hold, 1);
      end
      check("load_out_valid", bus.out_valid, 0);
      check("load_out_data", bus.out_data, exp_od);
    end
    bus.MAR = 6'($urandom);
    cyc();
    check("load_done_drop", bus.ld_done, 0);
  endtask

  initial begin
    bus.MAR = '0;
    bus.MDRIn = '0;
    bus.ld_len = '0;
    bus.ld_data = '0;
    idle_inputs();
    exp_od = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    cyc();
    do_reset();

    do_serve(6'd5, 1'b1, 10'h3FF);
    do_serve(6'd5, 1'b0, 10'h0);
    do_reset();
    do_serve(6'd5, 1'b0, 10'h0);

    ld_words.push_back(10'h101);
    ld_words.push_back(10'h202);
    ld_words.push_back(10'h3FF);
    do_load(3, 1'b1, -1);
    for (int i = 0; i < 3; i++) do_serve(6'(i), 1'b0, 10'h0);

    do_serve(6'd10, 1'b1, 10'h155);
    do_serve(6'd10, 1'b0, 10'h0);

    do_serve(6'd63, 1'b1, 10'h2AA);
    do_serve(6'd63, 1'b0, 10'h0);
    do_serve(6'd63, 1'b0, 10'h0);

    do_load(10, 1'b0, 4);
    for (int i = 0; i < 4; i++) do_serve(6'(i), 1'b0, 10'h0);

    do_load(0, 1'b0, -1);
    do_load(100, 1'b0, -1);
    for (int i = 0; i < 64; i++) do_serve(6'(i), 1'b0, 10'h0);

    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 20; k++) begin
        logic [5:0] a;
        a = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom);
        do_serve(a, 1'($urandom), 10'($urandom));
      end
      if ($urandom_range(0, 1) == 1) do_load($urandom_range(0, 80), 1'($urandom), -1);
    end
    for (int i = 0; i < 64; i++) do_serve(6'(i), 1'b0, 10'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
